// File: rtl/video_line_fetcher.sv
// video_line_fetcher: fetches one Hack screen row (32 x 16-bit words) per
// display line into a small prefetch FIFO and serialises it LSB-first as a
// 1-bit pixel stream centred in the 640x480 raster (512x256 window).
module video_line_fetcher #(
    parameter int H_OFFSET       = 64,
    parameter int V_OFFSET       = 112,
    parameter int WORDS_PER_LINE = 32,
    parameter int ROWS           = 256,
    parameter int ADDR_WIDTH     = 13,
    parameter int SCREEN_BASE    = 0,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_trigger_read,
    input  logic                  i_active,
    input  logic [9:0]            i_x,
    input  logic [9:0]            i_y,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ack,
    input  logic [15:0]           i_mem_data,
    output logic                  o_pixel,
    output logic                  o_busy,
    output logic                  o_underflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(WORDS_PER_LINE) + 1;
    localparam logic [9:0] Y_LO = 10'(V_OFFSET);
    localparam logic [9:0] Y_HI = 10'(V_OFFSET + ROWS);
    localparam logic [9:0] X_LO = 10'(H_OFFSET);
    localparam logic [9:0] X_HI = 10'(H_OFFSET + 16 * WORDS_PER_LINE);

    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;
    state_t state_q, state_d;

    logic [FIFO_DEPTH-1:0][15:0] fifo_mem;
    logic [PW-1:0]               wr_ptr, rd_ptr;
    logic [CW-1:0]               fifo_cnt;
    logic [WW-1:0]               words_left;
    logic [15:0]                 shreg;

    logic [9:0]            row;
    logic [3:0]            px_lo;
    logic                  y_in, x_in, win_pix, pop;
    logic                  load, flush, fifo_clr, push, push_store, pop_fifo, bypass, starve;
    logic                  fifo_empty, fifo_full;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [15:0]           pop_word;
    logic                  pix_d;

    // Raster decode: row of the screen and bit position within the current word.
    assign row     = i_y - Y_LO;
    assign px_lo   = i_x[3:0] - X_LO[3:0];
    assign y_in    = (i_y >= Y_LO) && (i_y < Y_HI);
    assign x_in    = (i_x >= X_LO) && (i_x < X_HI);
    assign win_pix = i_active && y_in && x_in;
    assign pop     = win_pix && (px_lo == 4'd0);

    assign line_addr = ADDR_WIDTH'(SCREEN_BASE) + ADDR_WIDTH'(row) * ADDR_WIDTH'(WORDS_PER_LINE);

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));

    // A trigger during FETCH means the previous line never completed.
    assign load  = i_trigger_read && y_in;
    assign flush = i_trigger_read && (state_q == FETCH);
    // Every accepted line starts from an empty FIFO so stale words never leak in.
    assign fifo_clr = flush || load;

    assign push       = o_mem_req && i_mem_ack && !flush;
    assign bypass     = pop && fifo_empty && push;
    assign push_store = push && !bypass;
    assign pop_fifo   = pop && !fifo_empty;
    assign starve     = pop && fifo_empty && !push;
    assign pop_word   = bypass ? i_mem_data : (fifo_empty ? 16'h0000 : fifo_mem[rd_ptr]);

    // Next-state and memory-request decode.
    always_comb begin
        state_d   = state_q;
        o_mem_req = 1'b0;
        o_busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) state_d = FETCH;
            end
            FETCH: begin
                o_busy    = 1'b1;
                o_mem_req = (words_left != '0) && !fifo_full;
                if (i_trigger_read)
                    state_d = y_in ? FETCH : IDLE;
                else if (o_mem_req && i_mem_ack && (words_left == WW'(1)))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Fetch address and remaining-word counter; address only moves on an ack.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_addr <= '0;
            words_left <= '0;
        end else if (load) begin
            o_mem_addr <= line_addr;
            words_left <= WW'(WORDS_PER_LINE);
        end else if (push) begin
            o_mem_addr <= o_mem_addr + ADDR_WIDTH'(1);
            words_left <= words_left - WW'(1);
        end
    end

    // FIFO storage; contents are meaningless until pointed at, so no reset.
    always_ff @(posedge i_clk) begin
        if (push_store && !i_rst) fifo_mem[wr_ptr] <= i_mem_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst || fifo_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_store) wr_ptr <= wr_ptr + PW'(1);
            if (pop_fifo)   rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt <= fifo_cnt + CW'(push_store) - CW'(pop_fifo);
        end
    end

    // Pixel select: a word boundary shows bit 0 of the fresh word directly.
    always_comb begin
        pix_d = 1'b0;
        if (pop)          pix_d = pop_word[0];
        else if (win_pix) pix_d = shreg[px_lo];
    end

    // Shift register, registered pixel and sticky underflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shreg       <= '0;
            o_pixel     <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (pop) shreg <= pop_word;
            o_pixel <= pix_d;
            if (starve || flush) o_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_video_line_fetcher.sv
// Bench for video_line_fetcher: raster driver, latency-configurable memory
// model, per-pixel and per-request scoreboards, line table plus corner cases.
module tb_video_line_fetcher;
    logic        i_clk = 1'b0;
    logic        i_rst, i_trigger_read, i_active, i_mem_ack;
    logic [9:0]  i_x, i_y;
    logic        o_mem_req, o_pixel, o_busy, o_underflow;
    logic [12:0] o_mem_addr;
    logic [15:0] i_mem_data;

    always #5 i_clk = ~i_clk;

    video_line_fetcher dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_trigger_read(i_trigger_read),
        .i_active(i_active), .i_x(i_x), .i_y(i_y),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
        .o_pixel(o_pixel), .o_busy(o_busy), .o_underflow(o_underflow)
    );

    typedef struct { bit care; logic v; int x; int y; } exp_t;
    typedef struct { int y; int lat; int mode; bit fetch; int first_addr; bit uf_exp; } vec_t;

    int          checks = 0, failures = 0;
    exp_t        pix_q[$];
    logic [12:0] req_log[$];
    int          ack_cnt = 0, mem_lat = 1, mem_mode = 0;
    logic        ovr_en = 1'b0, ovr_ack = 1'b0;
    logic [15:0] ovr_data = 16'h0000;
    bit          pix_chk = 1'b1;
    int          zeros, ones;
    logic        uf_pre;
    vec_t        vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_win(input logic act, input int x, input int y);
        return act && y >= 112 && y < 368 && x >= 64 && x < 576;
    endfunction

    // Reference pixel: bit (px mod 16) of screen word row*32 + px/16.
    function automatic logic exp_pix(input logic rst, input logic act, input int x, input int y, input int mode);
        logic [15:0] d;
        int px, w;
        if (rst || !in_win(act, x, y)) return 1'b0;
        px = x - 64;
        w  = (y - 112) * 32 + px / 16;
        d  = (mode != 0) ? 16'hFFFF : 16'(w);
        return d[px % 16];
    endfunction

    // Memory model: acks after mem_lat wait cycles; data = address or all ink.
    initial begin : mem_model
        int wait_cnt;
        wait_cnt   = 0;
        i_mem_ack  = 1'b0;
        i_mem_data = 16'h0000;
        forever begin
            @(posedge i_clk); #2;
            i_mem_ack = 1'b0;
            if (ovr_en) begin
                i_mem_ack  = ovr_ack;
                i_mem_data = ovr_data;
                wait_cnt   = 0;
            end else if (o_mem_req === 1'b1) begin
                if (wait_cnt >= mem_lat) begin
                    i_mem_ack  = 1'b1;
                    i_mem_data = (mem_mode != 0) ? 16'hFFFF : {3'b000, o_mem_addr};
                    req_log.push_back(o_mem_addr);
                    ack_cnt++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // One clock: queue the expected pixel for the current inputs, then compare it.
    task automatic cyc();
        exp_t e;
        e.care = pix_chk;
        e.x    = int'(i_x);
        e.y    = int'(i_y);
        e.v    = exp_pix(i_rst, i_active, e.x, e.y, mem_mode);
        pix_q.push_back(e);
        @(posedge i_clk); #1;
        e = pix_q.pop_front();
        if (e.care) check($sformatf("pixel x=%0d y=%0d", e.x, e.y), 32'(o_pixel), 32'(e.v));
    endtask

    // Line timing: 160 blanking cycles (x=640..799) then 640 active pixels.
    task automatic set_raster(input int c, input int y);
        i_y = 10'(y);
        if (c < 160) begin
            i_active = 1'b0;
            i_x      = 10'(640 + c);
        end else begin
            i_active = 1'b1;
            i_x      = 10'(c - 160);
        end
    endtask

    task automatic run_line(input int y, input int lat, input int mode, input bit fetch,
                            input int first_addr, input bit uf_exp, input bit chk);
        int ack_base;
        bit trig;
        mem_lat  = lat;
        mem_mode = mode;
        pix_chk  = chk;
        trig     = 1'b0;
        ack_base = ack_cnt;
        zeros    = 0;
        ones     = 0;
        for (int c = 0; c < 800; c++) begin
            bit prev_win;
            set_raster(c, y);
            i_trigger_read = (c == 16);
            prev_win = in_win(i_active, int'(i_x), y);
            cyc();
            i_trigger_read = 1'b0;
            if (c == 16) begin
                trig     = 1'b1;
                ack_base = ack_cnt;
                req_log.delete();
            end
            if (!chk && prev_win) begin
                if (o_pixel) ones++;
                else         zeros++;
            end
            if (c == 223) uf_pre = o_underflow;
            if (chk && trig)
                check($sformatf("busy y=%0d c=%0d", y, c), 32'(o_busy),
                      32'(fetch && (ack_cnt - ack_base) < 32));
        end
        if (chk) begin
            check($sformatf("req count y=%0d", y), req_log.size(), fetch ? 32 : 0);
            for (int i = 0; i < req_log.size() && i < 32; i++)
                check($sformatf("req addr y=%0d i=%0d", y, i), 32'(req_log[i]), first_addr + i);
            check($sformatf("busy end y=%0d", y), 32'(o_busy), 32'd0);
            check($sformatf("underflow end y=%0d", y), 32'(o_underflow), 32'(uf_exp));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        bit got;
        int ack_base;
        vecs[0] = '{112, 1, 0, 1'b1, 0,    1'b0};
        vecs[1] = '{111, 1, 0, 1'b0, 0,    1'b0};
        vecs[2] = '{368, 1, 0, 1'b0, 0,    1'b0};
        vecs[3] = '{367, 1, 0, 1'b1, 8160, 1'b0};
        vecs[4] = '{200, 1, 1, 1'b1, 2816, 1'b0};
        vecs[5] = '{300, 0, 0, 1'b1, 6016, 1'b0};

        i_rst = 1'b1; i_trigger_read = 1'b0; i_active = 1'b0; i_x = '0; i_y = '0;

        // Reset held three clocks under random inputs.
        ovr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_trigger_read = 1'($urandom_range(0, 1));
            i_active       = 1'($urandom_range(0, 1));
            i_x            = 10'($urandom_range(0, 799));
            i_y            = 10'($urandom_range(0, 524));
            ovr_ack        = 1'($urandom_range(0, 1));
            ovr_data       = 16'($urandom);
            cyc();
        end
        check("reset mem_req", 32'(o_mem_req), 32'd0);
        check("reset mem_addr", 32'(o_mem_addr), 32'd0);
        check("reset pixel", 32'(o_pixel), 32'd0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset underflow", 32'(o_underflow), 32'd0);
        ovr_en = 1'b0; i_rst = 1'b0; i_trigger_read = 1'b0; i_active = 1'b0;
        i_x = 10'd700; i_y = 10'd0;
        for (int i = 0; i < 4; i++) cyc();

        for (int i = 0; i < 6; i++)
            run_line(vecs[i].y, vecs[i].lat, vecs[i].mode, vecs[i].fetch,
                     vecs[i].first_addr, vecs[i].uf_exp, 1'b1);

        // Slow memory starves the serialiser partway through the line.
        run_line(112, 20, 1, 1'b1, 0, 1'b1, 1'b0);
        check("underflow before window", 32'(uf_pre), 32'd0);
        check("underflow after slow line", 32'(o_underflow), 32'd1);
        check("slow line blank pixels", 32'(zeros > 0), 32'd1);
        check("slow line ink pixels", 32'(ones > 0), 32'd1);
        // Next line fetches normally; the flag must stay set.
        run_line(150, 1, 0, 1'b1, 1216, 1'b1, 1'b1);

        // Reset in the middle of a fetch with one more ack on the bus.
        mem_lat = 1; mem_mode = 0; pix_chk = 1'b1;
        got = 1'b0;
        ack_base = ack_cnt;
        for (int c = 0; c < 800; c++) begin
            set_raster(c, 112);
            i_trigger_read = (c == 16);
            cyc();
            i_trigger_read = 1'b0;
            if (c == 16) ack_base = ack_cnt;
            if (ack_cnt - ack_base >= 5) begin
                got = 1'b1;
                break;
            end
        end
        check("fifth ack seen", 32'(got), 32'd1);
        i_rst = 1'b1; ovr_en = 1'b1; ovr_ack = 1'b1; ovr_data = 16'hFFFF;
        i_active = 1'b0; i_trigger_read = 1'b0;
        cyc();
        i_rst = 1'b0; ovr_en = 1'b0; ovr_ack = 1'b0;
        check("mid reset mem_req", 32'(o_mem_req), 32'd0);
        check("mid reset busy", 32'(o_busy), 32'd0);
        check("mid reset underflow", 32'(o_underflow), 32'd0);
        i_x = 10'd700; i_y = 10'd0;
        for (int i = 0; i < 20; i++) cyc();
        run_line(113, 1, 0, 1'b1, 32, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
